// File: rtl/fmap_pingpong.sv
// Double-buffered feature-map store: NUM_BANKS lane SRAMs, each split into two pages
// handed between producer and consumer. Define FMAP_PINGPONG_OUTREG_EN for a 2-cycle read.
module fmap_pingpong_bank #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  wr_page,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic                  rd_page,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
`ifdef FMAP_PINGPONG_OUTREG_EN
  input  logic                  rd_vld1,
`endif
  output logic [DATA_WIDTH-1:0] rd_data
);
  localparam int WORDS = 2 * DEPTH;

  logic [DATA_WIDTH-1:0] mem [WORDS];
  logic [DATA_WIDTH-1:0] rd_q;

  // Array has no reset so it maps onto SRAM; contents survive reset and page swaps.
  always_ff @(posedge clk)
    if (wr_en) mem[{wr_page, wr_addr}] <= wr_data;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)     rd_q <= '0;
    else if (rd_en) rd_q <= mem[{rd_page, rd_addr}];

`ifdef FMAP_PINGPONG_OUTREG_EN
  logic [DATA_WIDTH-1:0] rd_q2;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)       rd_q2 <= '0;
    else if (rd_vld1) rd_q2 <= rd_q;
  assign rd_data = rd_q2;
`else
  assign rd_data = rd_q;
`endif
endmodule

module fmap_pingpong #(
  parameter int NUM_BANKS  = 144,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_BANKS-1:0]                  wr_en,
  input  logic [NUM_BANKS-1:0][ADDR_WIDTH-1:0]  wr_addr,
  input  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]  wr_data,
  input  logic                                  wr_done,
  output logic                                  wr_ready,
  input  logic                                  rd_en,
  input  logic [NUM_BANKS-1:0][ADDR_WIDTH-1:0]  rd_addr,
  output logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]  rd_data,
  output logic                                  rd_data_valid,
  input  logic                                  rd_done,
  output logic                                  rd_avail,
  output logic                                  wr_page,
  output logic                                  rd_page,
  output logic                                  err_overflow,
  output logic                                  err_underflow
);
`ifdef FMAP_PINGPONG_OUTREG_EN
  localparam int STAGES = 2;
`else
  localparam int STAGES = 1;
`endif

  typedef enum logic {PG_EMPTY = 1'b0, PG_FULL = 1'b1} pg_state_t;

  pg_state_t pg_st [2];
  logic      wr_ptr, rd_ptr;
  logic      wr_ok, rd_ok, rd_acc;
  logic [STAGES:0] vld_pipe;

  assign wr_ready = (pg_st[wr_ptr] == PG_EMPTY);
  assign rd_avail = (pg_st[rd_ptr] == PG_FULL);
  assign wr_page  = wr_ptr;
  assign rd_page  = rd_ptr;
  assign wr_ok    = wr_done & wr_ready;
  assign rd_ok    = rd_done & rd_avail;
  assign rd_acc   = rd_en & rd_avail;

  // When both pointers meet only one handshake can be legal, so the two
  // state updates never collide on the same page.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pg_st[0]      <= PG_EMPTY;
      pg_st[1]      <= PG_EMPTY;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        pg_st[wr_ptr] <= PG_FULL;
        wr_ptr        <= ~wr_ptr;
      end
      if (rd_ok) begin
        pg_st[rd_ptr] <= PG_EMPTY;
        rd_ptr        <= ~rd_ptr;
      end
      if (!wr_ready && ((|wr_en) || wr_done)) err_overflow  <= 1'b1;
      if (!rd_avail && (rd_en || rd_done))    err_underflow <= 1'b1;
    end

  assign vld_pipe[0] = rd_acc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) vld_pipe[STAGES:1] <= '0;
    else        vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];

  assign rd_data_valid = vld_pipe[STAGES];

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    fmap_pingpong_bank #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (DEPTH),
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_bank (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_en  (wr_en[g] & wr_ready),
      .wr_page(wr_ptr),
      .wr_addr(wr_addr[g]),
      .wr_data(wr_data[g]),
      .rd_en  (rd_acc),
      .rd_page(rd_ptr),
      .rd_addr(rd_addr[g]),
`ifdef FMAP_PINGPONG_OUTREG_EN
      .rd_vld1(vld_pipe[1]),
`endif
      .rd_data(rd_data[g])
    );
  end
endmodule

// File: tb/tb_fmap_pingpong.sv
// Directed bench for fmap_pingpong: handshakes, error flags, reset retention, streaming.
module tb_fmap_pingpong;
  localparam int NB = 144;
  localparam int DW = 16;
  localparam int DP = 8;
  localparam int AW = 3;
`ifdef FMAP_PINGPONG_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic [NB-1:0]         wr_en;
  logic [NB-1:0][AW-1:0] wr_addr;
  logic [NB-1:0][DW-1:0] wr_data;
  logic                  wr_done, wr_ready;
  logic                  rd_en;
  logic [NB-1:0][AW-1:0] rd_addr;
  logic [NB-1:0][DW-1:0] rd_data;
  logic                  rd_data_valid, rd_done, rd_avail;
  logic                  wr_page, rd_page, err_overflow, err_underflow;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] smem [10][NB][DP];

  always #5 clk = ~clk;

  fmap_pingpong #(.NUM_BANKS(NB), .DATA_WIDTH(DW), .DEPTH(DP), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(wr_done), .wr_ready(wr_ready),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .rd_done(rd_done), .rd_avail(rd_avail), .wr_page(wr_page), .rd_page(rd_page),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input logic [3:0] t, input int b, input int a);
    pat = {t, 8'(b), 4'(a)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0; wr_done = 1'b0;
    rd_en = 1'b0; rd_addr = '0; rd_done = 1'b0;
  endtask

  task automatic fill(input logic [3:0] t, input bit done);
    for (int a = 0; a < DP; a++) begin
      idle();
      wr_en = '1;
      for (int b = 0; b < NB; b++) begin
        wr_addr[b] = AW'(a);
        wr_data[b] = pat(t, b, a);
      end
      wr_done = done && (a == DP - 1);
      tick();
    end
    idle();
  endtask

  // Reads the whole current read page and compares every bank against pattern t.
  task automatic drain(input logic [3:0] t, input bit done, input string tag);
    for (int c = 0; c < DP + LAT - 1; c++) begin
      idle();
      if (c < DP) begin
        rd_en = 1'b1;
        for (int b = 0; b < NB; b++) rd_addr[b] = AW'(c);
        rd_done = done && (c == DP - 1);
      end
      tick();
      if (c >= LAT - 1) begin
        int a, bad;
        a = c - (LAT - 1);
        bad = 0;
        for (int b = NB - 1; b >= 0; b--) if (rd_data[b] !== pat(t, b, a)) bad = b;
        chk(tag, rd_data[bad], pat(t, bad, a));
        chk({tag, "_vld"}, rd_data_valid, 1);
      end
    end
    idle();
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_rd_avail", rd_avail, 0);
    chk("rst_pages", {wr_page, rd_page}, 0);
    chk("rst_valid", rd_data_valid, 0);
    chk("rst_rd_data0", rd_data[0], 0);
    chk("rst_errs", {err_overflow, err_underflow}, 0);
    rst_n = 1'b1;
    tick();

    // Single word, then handoff.
    wr_en[0] = 1'b1; wr_addr[0] = 3'd3; wr_data[0] = 16'h1234;
    tick();
    idle(); wr_done = 1'b1;
    tick();
    idle();
    chk("hand_rd_avail", rd_avail, 1);
    chk("hand_wr_page", wr_page, 1);
    chk("hand_wr_ready", wr_ready, 1);
    chk("hand_rd_page", rd_page, 0);
    rd_en = 1'b1; rd_addr[0] = 3'd3;
    tick();
    idle();
    if (LAT == 2) begin
      chk("lat2_early_vld", rd_data_valid, 0);
      tick();
    end
    chk("single_vld", rd_data_valid, 1);
    chk("single_data", rd_data[0], 16'h1234);
    tick();
    chk("hold_vld", rd_data_valid, 0);
    chk("hold_data", rd_data[0], 16'h1234);
    rd_done = 1'b1;
    tick();
    idle();
    chk("rdone_rd_page", rd_page, 1);
    chk("rdone_rd_avail", rd_avail, 0);

    // Fill both pages; wr_page starts at 1 here.
    fill(4'hA, 1'b1);
    fill(4'hB, 1'b1);
    chk("full_wr_ready", wr_ready, 0);
    chk("full_ovf_pre", err_overflow, 0);
    wr_en[5] = 1'b1; wr_addr[5] = 3'd2; wr_data[5] = 16'hDEAD;
    tick();
    idle();
    chk("ovf_wr", err_overflow, 1);
    drain(4'hA, 1'b0, "page1_intact");

    // Both full: only rd_done is legal.
    wr_done = 1'b1; rd_done = 1'b1;
    tick();
    idle();
    chk("both_rd_page", rd_page, 0);
    chk("both_wr_page", wr_page, 1);
    chk("both_wr_ready", wr_ready, 1);
    chk("both_rd_avail", rd_avail, 1);
    chk("both_ovf", err_overflow, 1);
    drain(4'hB, 1'b1, "page0_data");
    chk("empty_rd_avail", rd_avail, 0);

    // Reset mid-read, then check page 1 retention.
    do_reset();
    fill(4'hC, 1'b1);
    fill(4'hD, 1'b1);
    rd_en = 1'b1; rd_addr = '0;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", rd_data_valid, 0);
    chk("arst_rd_avail", rd_avail, 0);
    chk("arst_wr_ready", wr_ready, 1);
    chk("arst_pages", {wr_page, rd_page}, 0);
    chk("arst_errs", {err_overflow, err_underflow}, 0);
    chk("arst_rd_data", rd_data[7], 0);
    idle();
    #2 rst_n = 1'b1;
    tick();
    fill(4'hE, 1'b1);
    drain(4'hE, 1'b1, "refill_page0");
    wr_done = 1'b1;
    tick();
    idle();
    drain(4'hD, 1'b1, "retain_page1");

    // Illegal read side.
    chk("unf_pre", err_underflow, 0);
    rd_en = 1'b1;
    tick();
    idle();
    tick();
    chk("unf_vld", rd_data_valid, 0);
    chk("unf_flag", err_underflow, 1);
    rd_done = 1'b1;
    tick();
    idle();
    chk("unf_pages", {wr_page, rd_page}, 0);
    chk("unf_wr_ready", wr_ready, 1);
    chk("unf_ovf", err_overflow, 0);

    // Streaming: write page k while reading page k-1.
    do_reset();
    for (int k = 0; k < 10; k++)
      for (int b = 0; b < NB; b++)
        for (int a = 0; a < DP; a++) smem[k][b][a] = DW'($urandom);
    for (int k = 0; k <= 10; k++) begin
      for (int c = 0; c < DP + LAT - 1; c++) begin
        idle();
        if (c < DP && k < 10) begin
          wr_en = '1;
          for (int b = 0; b < NB; b++) begin
            wr_addr[b] = AW'(c);
            wr_data[b] = smem[k][b][c];
          end
          wr_done = (c == DP - 1);
        end
        if (c < DP && k > 0) begin
          rd_en = 1'b1;
          for (int b = 0; b < NB; b++) rd_addr[b] = AW'(c);
          rd_done = (c == DP - 1);
        end
        tick();
        if (k > 0 && c >= LAT - 1) begin
          int a, bad;
          a = c - (LAT - 1);
          bad = 0;
          for (int b = NB - 1; b >= 0; b--) if (rd_data[b] !== smem[k-1][b][a]) bad = b;
          chk("strm_data", rd_data[bad], smem[k-1][bad][a]);
          chk("strm_vld", rd_data_valid, 1);
        end
      end
    end
    idle();
    tick();
    chk("strm_errs", {err_overflow, err_underflow}, 0);
    chk("strm_end_state", {wr_ready, rd_avail}, 2'b10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
